// File: rtl/lsu_req_arbiter.sv
// Shares one LSU request port between two load-store pipelines: round-robin grant with hold-until-accept,
// credit limit on outstanding requests, and an in-order ID FIFO that steers responses back to the issuer.
module lsu_req_arbiter #(
  parameter int Depth = 4,
  parameter int InfoW = 32,
  parameter int MemW  = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     req0_valid_i,
  input  logic [InfoW-1:0]         req0_info_i,
  output logic                     req0_rdy_o,
  input  logic                     req1_valid_i,
  input  logic [InfoW-1:0]         req1_info_i,
  output logic                     req1_rdy_o,
  output logic                     lsu_req_o,
  output logic [InfoW-1:0]         lsu_req_info_o,
  input  logic                     lsu_req_done_i,
  input  logic                     lsu_resp_valid_i,
  input  logic                     load_err_i,
  input  logic                     store_err_i,
  input  logic [MemW-1:0]          data_rdata_i,
  output logic                     resp0_valid_o,
  output logic                     resp1_valid_o,
  output logic                     resp_err_o,
  output logic [MemW-1:0]          resp_rdata_o,
  output logic [$clog2(Depth):0]   outstanding_o,
  output logic                     busy_o
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;
  localparam logic [InfoW-1:0] NULL_LSU_REQ_INFO = '0;

  logic [1:0]      valid;
  logic            rr_ptr_reg;
  logic            lock_reg;
  logic            locked_id_reg;
  logic [PtrW-1:0] wr_ptr_reg;
  logic [PtrW-1:0] rd_ptr_reg;
  logic [CntW-1:0] count_reg;
  logic [Depth-1:0] id_mem_reg;

  logic grant;
  logic credit_ok;
  logic accept;
  logic pop;
  logic fifo_empty;
  logic head_id;

  assign valid = {req1_valid_i, req0_valid_i};

  always_comb begin
    grant = rr_ptr_reg;
    if (lock_reg) begin
      grant = locked_id_reg;
    end else if (valid == 2'b01) begin
      grant = 1'b0;
    end else if (valid == 2'b10) begin
      grant = 1'b1;
    end
  end

  // Credit check uses the registered count, so a pop never frees a slot within the same cycle.
  assign credit_ok  = (count_reg < CntW'(Depth));
  assign lsu_req_o  = valid[grant] & credit_ok;
  assign accept     = lsu_req_o & lsu_req_done_i;
  assign req0_rdy_o = accept & ~grant;
  assign req1_rdy_o = accept & grant;

  assign lsu_req_info_o = !lsu_req_o ? NULL_LSU_REQ_INFO :
                          (grant ? req1_info_i : req0_info_i);

  assign fifo_empty    = (count_reg == '0);
  assign head_id       = id_mem_reg[rd_ptr_reg];
  assign pop           = lsu_resp_valid_i & ~fifo_empty;
  assign resp0_valid_o = pop & ~head_id;
  assign resp1_valid_o = pop & head_id;
  assign resp_err_o    = load_err_i | store_err_i;
  assign resp_rdata_o  = data_rdata_i;
  assign outstanding_o = count_reg;
  assign busy_o        = lsu_req_o | ~fifo_empty;

  // Flush only releases the lock; accepted requests still expect their responses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_reg    <= 1'b0;
      lock_reg      <= 1'b0;
      locked_id_reg <= 1'b0;
    end else begin
      if (accept) begin
        lock_reg   <= 1'b0;
        rr_ptr_reg <= ~grant;
      end else if (lsu_req_o) begin
        lock_reg      <= 1'b1;
        locked_id_reg <= grant;
      end
      if (flush_i) begin
        lock_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (accept) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)    rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({accept, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < Depth; gi++) begin : g_id_mem
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          id_mem_reg[gi] <= 1'b0;
        end else if (accept && (wr_ptr_reg == PtrW'(gi))) begin
          id_mem_reg[gi] <= grant;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_lsu_req_arbiter.sv
// Directed bench for lsu_req_arbiter: each scenario task drives cycles and checks against hand-derived values.
module tb_lsu_req_arbiter;

  localparam int DEPTH = 4;
  localparam logic [31:0] I0 = 32'hA0A0_0010;
  localparam logic [31:0] I1 = 32'hB1B1_0021;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [31:0] req0_info = I0, req1_info = I1;
  logic        req0_rdy, req1_rdy;
  logic        lsu_req;
  logic [31:0] lsu_req_info;
  logic        lsu_req_done = 1'b0;
  logic        lsu_resp_valid = 1'b0;
  logic        load_err = 1'b0, store_err = 1'b0;
  logic [31:0] data_rdata = '0;
  logic        resp0_valid, resp1_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [2:0]  outstanding;
  logic        busy;
  logic [4:0]  ctl_obs;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lsu_req_arbiter #(.Depth(DEPTH), .InfoW(32), .MemW(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .req0_valid_i(req0_valid), .req0_info_i(req0_info), .req0_rdy_o(req0_rdy),
    .req1_valid_i(req1_valid), .req1_info_i(req1_info), .req1_rdy_o(req1_rdy),
    .lsu_req_o(lsu_req), .lsu_req_info_o(lsu_req_info), .lsu_req_done_i(lsu_req_done),
    .lsu_resp_valid_i(lsu_resp_valid), .load_err_i(load_err), .store_err_i(store_err),
    .data_rdata_i(data_rdata), .resp0_valid_o(resp0_valid), .resp1_valid_o(resp1_valid),
    .resp_err_o(resp_err), .resp_rdata_o(resp_rdata), .outstanding_o(outstanding), .busy_o(busy)
  );

  // {lsu_req, req0_rdy, req1_rdy, resp0_valid, resp1_valid}
  assign ctl_obs = {lsu_req, req0_rdy, req1_rdy, resp0_valid, resp1_valid};

  // Inputs change just after the falling edge; outputs are observed 1 ns later.
  task automatic drive(input logic v0, input logic v1, input logic done, input logic resp, input logic fl);
    @(negedge clk);
    req0_valid = v0; req1_valid = v1; lsu_req_done = done; lsu_resp_valid = resp; flush = fl;
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (ctl_obs !== 5'b0 || outstanding !== 3'd0 || busy !== 1'b0 || lsu_req_info !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ctl=%b out=%0d busy=%b info=%h expected all zero",
               ctl_obs, outstanding, busy, lsu_req_info);
    end
    @(negedge clk); rst_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_round_robin();
    logic [4:0]  exp_ctl  [5] = '{5'b11000, 5'b10110, 5'b11001, 5'b10110, 5'b00001};
    logic [2:0]  exp_out  [5] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd1};
    logic [31:0] exp_info [5] = '{I0, I1, I0, I1, 32'h0};
    for (int c = 0; c < 5; c++) begin
      load_err = (c == 2); data_rdata = (c == 2) ? 32'hDEAD_BEEF : 32'h0;
      drive(c < 4, c < 4, 1'b1, c >= 1, 1'b0);
      $display("rr c%0d ctl=%b out=%0d info=%h", c, ctl_obs, outstanding, lsu_req_info);
      n_checks++;
      if (ctl_obs !== exp_ctl[c]) begin n_fail++; $display("FAIL rr_ctl c%0d: got %b expected %b", c, ctl_obs, exp_ctl[c]); end
      n_checks++;
      if (outstanding !== exp_out[c]) begin n_fail++; $display("FAIL rr_out c%0d: got %0d expected %0d", c, outstanding, exp_out[c]); end
      n_checks++;
      if (lsu_req_info !== exp_info[c]) begin n_fail++; $display("FAIL rr_info c%0d: got %h expected %h", c, lsu_req_info, exp_info[c]); end
      if (c == 2) begin
        n_checks++;
        if (resp_err !== 1'b1 || resp_rdata !== 32'hDEAD_BEEF) begin
          n_fail++; $display("FAIL rr_passthru: got err=%b rdata=%h expected 1 deadbeef", resp_err, resp_rdata);
        end
      end
    end
    load_err = 1'b0; data_rdata = '0;
    drive(0, 0, 0, 0, 0);
    n_checks++;
    if (outstanding !== 3'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rr_drain: got out=%0d busy=%b expected 0 0", outstanding, busy);
    end
  endtask

  task automatic test_hold();
    logic       v0  [6] = '{0, 1, 1, 1, 1, 0};
    logic       v1  [6] = '{1, 1, 1, 1, 0, 0};
    logic       dn  [6] = '{0, 0, 0, 1, 1, 0};
    logic       rs  [6] = '{0, 0, 0, 0, 1, 1};
    logic [4:0] exp_ctl  [6] = '{5'b10000, 5'b10000, 5'b10000, 5'b10100, 5'b11001, 5'b00010};
    logic [2:0] exp_out  [6] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1};
    logic [31:0] exp_info [6] = '{I1, I1, I1, I1, I0, 32'h0};
    for (int c = 0; c < 6; c++) begin
      drive(v0[c], v1[c], dn[c], rs[c], 1'b0);
      $display("hold c%0d ctl=%b out=%0d info=%h", c, ctl_obs, outstanding, lsu_req_info);
      n_checks++;
      if (ctl_obs !== exp_ctl[c]) begin n_fail++; $display("FAIL hold_ctl c%0d: got %b expected %b", c, ctl_obs, exp_ctl[c]); end
      n_checks++;
      if (outstanding !== exp_out[c]) begin n_fail++; $display("FAIL hold_out c%0d: got %0d expected %0d", c, outstanding, exp_out[c]); end
      n_checks++;
      if (lsu_req_info !== exp_info[c]) begin n_fail++; $display("FAIL hold_info c%0d: got %h expected %h", c, lsu_req_info, exp_info[c]); end
    end
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_credit();
    logic       v0  [12] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
    logic       rs  [12] = '{0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 1, 0};
    logic [4:0] exp_ctl [12] = '{5'b11000, 5'b11000, 5'b11000, 5'b11000, 5'b00000, 5'b00010,
                                 5'b11000, 5'b00010, 5'b00010, 5'b00010, 5'b00010, 5'b00000};
    logic [2:0] exp_out [12] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd3, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    for (int c = 0; c < 12; c++) begin
      drive(v0[c], 1'b0, 1'b1, rs[c], 1'b0);
      $display("credit c%0d ctl=%b out=%0d busy=%b", c, ctl_obs, outstanding, busy);
      n_checks++;
      if (ctl_obs !== exp_ctl[c]) begin n_fail++; $display("FAIL credit_ctl c%0d: got %b expected %b", c, ctl_obs, exp_ctl[c]); end
      n_checks++;
      if (outstanding !== exp_out[c]) begin n_fail++; $display("FAIL credit_out c%0d: got %0d expected %0d", c, outstanding, exp_out[c]); end
      if (c == 4) begin
        n_checks++;
        if (lsu_req_info !== 32'h0 || busy !== 1'b1) begin
          n_fail++; $display("FAIL credit_full: got info=%h busy=%b expected 0 1", lsu_req_info, busy);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic       v0 [6] = '{1, 0, 1, 0, 0, 0};
    logic       v1 [6] = '{0, 1, 0, 0, 0, 0};
    logic       rs [6] = '{0, 0, 1, 1, 1, 0};
    logic [4:0] exp_ctl [6] = '{5'b11000, 5'b10100, 5'b11010, 5'b00001, 5'b00010, 5'b00000};
    logic [2:0] exp_out [6] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd1, 3'd0};
    for (int c = 0; c < 6; c++) begin
      drive(v0[c], v1[c], 1'b1, rs[c], 1'b0);
      $display("b2b c%0d ctl=%b out=%0d", c, ctl_obs, outstanding);
      n_checks++;
      if (ctl_obs !== exp_ctl[c]) begin n_fail++; $display("FAIL b2b_ctl c%0d: got %b expected %b", c, ctl_obs, exp_ctl[c]); end
      n_checks++;
      if (outstanding !== exp_out[c]) begin n_fail++; $display("FAIL b2b_out c%0d: got %0d expected %0d", c, outstanding, exp_out[c]); end
    end
  endtask

  task automatic test_flush();
    logic       v0 [6] = '{1, 0, 1, 1, 0, 0};
    logic       v1 [6] = '{0, 1, 1, 0, 0, 0};
    logic       dn [6] = '{1, 0, 0, 1, 0, 0};
    logic       rs [6] = '{0, 0, 0, 1, 1, 0};
    logic       fl [6] = '{0, 0, 1, 0, 0, 0};
    logic [4:0] exp_ctl [6] = '{5'b11000, 5'b10000, 5'b10000, 5'b11010, 5'b00010, 5'b00000};
    logic [2:0] exp_out [6] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0};
    logic [31:0] exp_info [6] = '{I0, I1, I1, I0, 32'h0, 32'h0};
    for (int c = 0; c < 6; c++) begin
      drive(v0[c], v1[c], dn[c], rs[c], fl[c]);
      $display("flush c%0d ctl=%b out=%0d info=%h", c, ctl_obs, outstanding, lsu_req_info);
      n_checks++;
      if (ctl_obs !== exp_ctl[c]) begin n_fail++; $display("FAIL flush_ctl c%0d: got %b expected %b", c, ctl_obs, exp_ctl[c]); end
      n_checks++;
      if (outstanding !== exp_out[c]) begin n_fail++; $display("FAIL flush_out c%0d: got %0d expected %0d", c, outstanding, exp_out[c]); end
      n_checks++;
      if (lsu_req_info !== exp_info[c]) begin n_fail++; $display("FAIL flush_info c%0d: got %h expected %h", c, lsu_req_info, exp_info[c]); end
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (ctl_obs !== 5'b10000 || outstanding !== 3'd3) begin
      n_fail++; $display("FAIL rstmid_pre: got ctl=%b out=%0d expected 10000 3", ctl_obs, outstanding);
    end
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0; lsu_req_done = 1'b0; rst_n = 1'b0;
    #1;
    $display("rstmid in reset ctl=%b out=%0d busy=%b", ctl_obs, outstanding, busy);
    n_checks++;
    if (ctl_obs !== 5'b0 || outstanding !== 3'd0 || busy !== 1'b0 || lsu_req_info !== 32'h0) begin
      n_fail++; $display("FAIL rstmid_outputs: got ctl=%b out=%0d busy=%b info=%h expected all zero",
                         ctl_obs, outstanding, busy, lsu_req_info);
    end
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    $display("rstmid after ctl=%b out=%0d info=%h", ctl_obs, outstanding, lsu_req_info);
    n_checks++;
    if (ctl_obs !== 5'b11000 || outstanding !== 3'd0 || lsu_req_info !== I0) begin
      n_fail++; $display("FAIL rstmid_grant: got ctl=%b out=%0d info=%h expected 11000 0 %h",
                         ctl_obs, outstanding, lsu_req_info, I0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (ctl_obs !== 5'b00010 || outstanding !== 3'd1) begin
      n_fail++; $display("FAIL rstmid_resp: got ctl=%b out=%0d expected 00010 1", ctl_obs, outstanding);
    end
    drive(0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_hold();
    test_credit();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
